// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the hazard controller
package hazard_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_t;
    localparam int DEFAULT_MULDIV_LATENCY = 32;
endpackage

// File: rtl/hazard_unit_muldiv_tracker.sv
// muldiv_tracker: follows the multiply/divide busy window and flags the HI/LO write cycle
module muldiv_tracker
    import hazard_pkg::*;
#(
    parameter int MULDIV_LATENCY = DEFAULT_MULDIV_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic mulDivStartE,
    output logic mulDivBusy,
    output logic hiLoWrite
);
    localparam int CW = $clog2(MULDIV_LATENCY);
    muldiv_state_t state, nextState;
    logic [CW-1:0] count, nextCount;
    // state and countdown registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= nextState;
            count <= nextCount;
        end
    end
    // next state: a start is only honoured from IDLE
    always_comb begin
        nextState = state;
        nextCount = count;
        if (state == IDLE && mulDivStartE) begin
            nextState = BUSY;
            nextCount = CW'(MULDIV_LATENCY - 1);
        end else if (state == BUSY) begin
            nextState = count == '0 ? DONE : BUSY;
            nextCount = count == '0 ? count : count - 1'b1;
        end else if (state == DONE) begin
            nextState = IDLE;
        end
    end
    assign mulDivBusy = state != IDLE;
    assign hiLoWrite  = state == DONE;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: detects non-forwardable hazards in decode and counts stall cycles
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MULDIV_LATENCY = DEFAULT_MULDIV_LATENCY,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemReadE,
    input  logic             RegWriteE,
    input  logic [4:0]       RAddrE,
    input  logic             MemReadM,
    input  logic [4:0]       RAddrM,
    input  logic [4:0]       RsAddrD,
    input  logic [4:0]       RtAddrD,
    input  logic             BranchD,
    input  logic             MulDivD,
    input  logic             HiLoReadD,
    input  logic             MulDivStartE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             MulDivBusy,
    output logic             HiLoWrite,
    output logic [CNT_W-1:0] StallCount
);
    logic matchE, matchM, loadStall, branchStall, mulDivStall, stall;
    muldiv_tracker #(.MULDIV_LATENCY(MULDIV_LATENCY)) tracker (
        .clk         (clk),
        .rst         (rst),
        .mulDivStartE(MulDivStartE),
        .mulDivBusy  (MulDivBusy),
        .hiLoWrite   (HiLoWrite)
    );
    // r0 is hardwired zero, so it never creates a dependency
    always_comb begin
        matchE      = RAddrE != 5'd0 && (RAddrE == RsAddrD || RAddrE == RtAddrD);
        matchM      = RAddrM != 5'd0 && (RAddrM == RsAddrD || RAddrM == RtAddrD);
        loadStall   = MemReadE && matchE;
        branchStall = BranchD && ((RegWriteE && matchE) || (MemReadM && matchM));
        mulDivStall = MulDivBusy && (HiLoReadD || MulDivD);
        stall       = loadStall || branchStall || mulDivStall;
    end
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    // saturating stall-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) StallCount <= '0;
        else if (stall && !(&StallCount)) StallCount <= StallCount + 1'b1;
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of hazard detection, mult/div tracking and stall counting
module tb_hazard_unit;
    logic clk = 0, rst = 1;
    logic MemReadE, RegWriteE, MemReadM, BranchD, MulDivD, HiLoReadD, MulDivStartE;
    logic [4:0] RAddrE, RAddrM, RsAddrD, RtAddrD;
    logic StallF, StallD, FlushE, MulDivBusy, HiLoWrite;
    logic [31:0] StallCount;
    int tests = 0, fails = 0;
    logic [31:0] expCount = 0;

    hazard_unit #(.MULDIV_LATENCY(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .MemReadE(MemReadE), .RegWriteE(RegWriteE), .RAddrE(RAddrE),
        .MemReadM(MemReadM), .RAddrM(RAddrM), .RsAddrD(RsAddrD), .RtAddrD(RtAddrD),
        .BranchD(BranchD), .MulDivD(MulDivD), .HiLoReadD(HiLoReadD), .MulDivStartE(MulDivStartE),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .MulDivBusy(MulDivBusy),
        .HiLoWrite(HiLoWrite), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic clearInputs();
        {MemReadE, RegWriteE, MemReadM, BranchD, MulDivD, HiLoReadD, MulDivStartE} = '0;
        {RAddrE, RAddrM, RsAddrD, RtAddrD} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkStall(input string name, input logic exp);
        tests++;
        if ({StallF, StallD, FlushE} !== {3{exp}}) begin
            fails++;
            $display("FAIL %s: StallF/StallD/FlushE=%b%b%b expected %b%b%b", name, StallF, StallD, FlushE, exp, exp, exp);
        end
    endtask

    task automatic checkCount(input string name);
        tests++;
        if (StallCount !== expCount) begin
            fails++;
            $display("FAIL %s: StallCount=%0d expected %0d", name, StallCount, expCount);
        end
    endtask

    task automatic test_reset();
        clearInputs();
        #2;
        tests++;
        if ({StallF, StallD, FlushE, MulDivBusy, HiLoWrite} !== 5'b0 || StallCount !== 32'd0) begin
            fails++;
            $display("FAIL reset: outs=%b count=%0d expected 00000 and 0", {StallF, StallD, FlushE, MulDivBusy, HiLoWrite}, StallCount);
        end
        @(negedge clk);
        rst = 0;
        step();
        checkCount("reset_count");
    endtask

    task automatic test_load_use();
        MemReadE = 1; RAddrE = 5; RsAddrD = 5;
        #1 checkStall("load_use", 1);
        step(); expCount++;
        checkCount("load_use_count");
        clearInputs(); MemReadM = 1; RAddrM = 5; RsAddrD = 5;
        #1 checkStall("load_use_in_mem", 0);
        step();
        checkCount("load_use_cleared_count");
        clearInputs(); MemReadE = 1; RAddrE = 7; RtAddrD = 7;
        #1 checkStall("load_use_rt", 1);
        step(); expCount++;
        checkCount("load_use_rt_count");
        clearInputs(); MemReadE = 1; RAddrE = 7; RsAddrD = 6; RtAddrD = 8;
        #1 checkStall("load_no_match", 0);
        step();
    endtask

    task automatic test_r0();
        clearInputs(); MemReadE = 1; RAddrE = 0; RtAddrD = 0;
        #1 checkStall("r0_load", 0);
        BranchD = 1; RegWriteE = 1; MemReadM = 1; RAddrM = 0;
        #1 checkStall("r0_branch", 0);
        step();
        checkCount("r0_count");
    endtask

    task automatic test_branch_alu();
        clearInputs(); BranchD = 1; RegWriteE = 1; RAddrE = 8; RtAddrD = 8;
        #1 checkStall("branch_alu", 1);
        step(); expCount++;
        checkCount("branch_alu_count");
        clearInputs(); BranchD = 1; RAddrM = 8; RtAddrD = 8;
        #1 checkStall("branch_alu_in_mem", 0);
        step();
        checkCount("branch_alu_done_count");
        clearInputs(); RegWriteE = 1; RAddrE = 8; RtAddrD = 8;
        #1 checkStall("alu_no_branch", 0);
        step();
    endtask

    task automatic test_branch_load();
        clearInputs(); BranchD = 1; MemReadE = 1; RegWriteE = 1; RAddrE = 9; RsAddrD = 9;
        #1 checkStall("branch_load_e", 1);
        step(); expCount++;
        clearInputs(); BranchD = 1; MemReadM = 1; RAddrM = 9; RsAddrD = 9;
        #1 checkStall("branch_load_m", 1);
        step(); expCount++;
        checkCount("branch_load_count");
        clearInputs(); BranchD = 1; RsAddrD = 9;
        #1 checkStall("branch_load_done", 0);
        step();
    endtask

    task automatic test_back_to_back();
        clearInputs(); MemReadE = 1; RegWriteE = 1; RAddrE = 3; RsAddrD = 3; BranchD = 1;
        #1 checkStall("simultaneous", 1);
        step(); expCount++;
        checkCount("simultaneous_count");
        clearInputs();
    endtask

    task automatic test_muldiv();
        clearInputs(); MulDivStartE = 1; HiLoReadD = 1;
        #1 checkStall("muldiv_idle_read", 0);
        step();
        MulDivStartE = 0;
        for (int i = 1; i <= 5; i++) begin
            tests++;
            if (MulDivBusy !== 1'b1 || HiLoWrite !== (i == 5)) begin
                fails++;
                $display("FAIL muldiv_cycle%0d: busy=%b hilo=%b expected 1 %b", i, MulDivBusy, HiLoWrite, i == 5);
            end
            checkStall("muldiv_stall", 1);
            step(); expCount++;
        end
        tests++;
        if (MulDivBusy !== 1'b0 || HiLoWrite !== 1'b0) begin
            fails++;
            $display("FAIL muldiv_idle: busy=%b hilo=%b expected 0 0", MulDivBusy, HiLoWrite);
        end
        checkStall("muldiv_after", 0);
        checkCount("muldiv_count");
        clearInputs();
    endtask

    task automatic test_async_reset();
        MulDivStartE = 1;
        step();
        MulDivStartE = 0; MulDivD = 1;
        step(); expCount++;
        checkStall("reset_busy_stall", 1);
        #2 rst = 1;
        #1;
        expCount = 0;
        tests++;
        if (MulDivBusy !== 1'b0 || StallF !== 1'b0 || StallCount !== 32'd0) begin
            fails++;
            $display("FAIL async_reset: busy=%b stall=%b count=%0d expected 0 0 0", MulDivBusy, StallF, StallCount);
        end
        @(negedge clk);
        rst = 0; MulDivD = 0; MulDivStartE = 1;
        step();
        MulDivStartE = 0;
        tests++;
        if (MulDivBusy !== 1'b1 || HiLoWrite !== 1'b0) begin
            fails++;
            $display("FAIL restart: busy=%b hilo=%b expected 1 0", MulDivBusy, HiLoWrite);
        end
        checkCount("restart_count");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_r0();
        test_branch_alu();
        test_branch_load();
        test_back_to_back();
        test_muldiv();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
